// File: rtl/lane_score_engine_if.sv
// Bus bundle for lane_score_engine: advance/spawn/press inputs and lane/score status outputs.
interface lane_score_engine_if #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned SCORE_W = 8
);
  logic                     tick;
  logic [LANES-1:0]         spawn;
  logic [LANES-1:0]         press;
  logic [LANES*DEPTH-1:0]   lanes;
  logic [SCORE_W-1:0]       score;
  logic [7:0]               combo;
  logic                     game_over;

  modport master (
    output tick, spawn, press,
    input  lanes, score, combo, game_over
  );

  modport slave (
    input  tick, spawn, press,
    output lanes, score, combo, game_over
  );
endinterface

// File: rtl/lane_score_engine.sv
// Parametrised note-lane shifter, hit/miss judge and clamped score/combo keeper.
// Optional macro COMBO_BONUS_EN: hits earn one extra point while the registered combo is >= 8.
module lane_score_engine #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned SCORE_W  = 8,
  parameter int unsigned HIT_PTS  = 3,
  parameter int unsigned MISS_PTS = 1,
  parameter int unsigned BAD_PTS  = 1
) (
  input logic                clk,
  input logic                reset,
  lane_score_engine_if.slave bus
);
  localparam int unsigned SUM_W = SCORE_W + 4;
  localparam logic [SUM_W-1:0] MAX_EXT = {4'b0000, {SCORE_W{1'b1}}};

  logic [LANES-1:0][DEPTH-1:0] lane_q, lane_d;
  logic [SCORE_W-1:0]          score_q, score_d;
  logic [7:0]                  combo_q, combo_d;
  logic                        over_q;

  logic [SUM_W-1:0] gains, losses, hit_pts, base, diff;
  logic [8:0]       hit_cnt, combo_sum;
  logic             fault;
  logic [DEPTH-1:0] row;

  always_comb begin
`ifdef COMBO_BONUS_EN
    hit_pts = (combo_q >= 8'd8) ? SUM_W'(HIT_PTS + 1) : SUM_W'(HIT_PTS);
`else
    hit_pts = SUM_W'(HIT_PTS);
`endif
    gains   = '0;
    losses  = '0;
    hit_cnt = '0;
    fault   = 1'b0;
    lane_d  = lane_q;
    row     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      row = lane_q[l];
      if (bus.press[l]) begin
        if (row[DEPTH-1]) begin
          row[DEPTH-1] = 1'b0;
          gains        = gains + hit_pts;
          hit_cnt      = hit_cnt + 9'd1;
        end else begin
          losses = losses + SUM_W'(BAD_PTS);
          fault  = 1'b1;
        end
      end else if (bus.tick && row[DEPTH-1]) begin
        losses = losses + SUM_W'(MISS_PTS);
        fault  = 1'b1;
      end
      // The hit clear happens before the shift, so row DEPTH-2 still lands in the hit row.
      lane_d[l] = bus.tick ? {row[DEPTH-2:0], bus.spawn[l]} : row;
    end

    base = {4'b0000, score_q} + gains;
    diff = base - losses;
    if (losses >= base) begin
      score_d = '0;
    end else if (diff > MAX_EXT) begin
      score_d = '1;
    end else begin
      score_d = diff[SCORE_W-1:0];
    end

    combo_sum = {1'b0, combo_q} + hit_cnt;
    if (fault) begin
      combo_d = '0;
    end else if (combo_sum[8]) begin
      combo_d = '1;
    end else begin
      combo_d = combo_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
      over_q  <= 1'b0;
    end else if (!over_q) begin
      lane_q  <= lane_d;
      score_q <= score_d;
      combo_q <= combo_d;
      over_q  <= (score_d == '1);
    end
  end

  assign bus.lanes     = lane_q;
  assign bus.score     = score_q;
  assign bus.combo     = combo_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_lane_score_engine.sv
// Directed bench for lane_score_engine with a per-cycle integer reference model.
module tb_lane_score_engine;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;

  always #5 clk = ~clk;

  lane_score_engine_if #(.LANES(4), .DEPTH(8), .SCORE_W(8)) bus ();

  lane_score_engine #(
    .LANES(4), .DEPTH(8), .SCORE_W(8), .HIT_PTS(3), .MISS_PTS(1), .BAD_PTS(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: note occupancy as integers per lane/row, score and combo as plain ints.
  int lane_m [4][8];
  int score_m;
  int combo_m;
  bit over_m;

  function automatic int pts_now();
`ifdef COMBO_BONUS_EN
    return (combo_m >= 8) ? 4 : 3;
`else
    return 3;
`endif
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 8; i++) lane_m[l][i] = 0;
    score_m = 0;
    combo_m = 0;
    over_m  = 1'b0;
  endtask

  task automatic model_apply(input bit t, input logic [3:0] sp, input logic [3:0] pr);
    int gain = 0;
    int loss = 0;
    int hits = 0;
    int s;
    int pts;
    bit broke = 1'b0;
    if (over_m) return;
    pts = pts_now();
    for (int l = 0; l < 4; l++) begin
      if (pr[l] && lane_m[l][7] == 1) begin
        gain += pts;
        hits++;
        lane_m[l][7] = 0;
      end else if (pr[l]) begin
        loss += 1;
        broke = 1'b1;
      end
      if (t) begin
        if (lane_m[l][7] == 1) begin
          loss += 1;
          broke = 1'b1;
        end
        for (int i = 7; i > 0; i--) lane_m[l][i] = lane_m[l][i-1];
        lane_m[l][0] = sp[l] ? 1 : 0;
      end
    end
    s = score_m + gain - loss;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    score_m = s;
    combo_m = broke ? 0 : ((combo_m + hits > 255) ? 255 : combo_m + hits);
    over_m  = (score_m == 255);
  endtask

  function automatic logic [31:0] model_lanes();
    logic [31:0] v = '0;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 8; i++) v[l*8+i] = (lane_m[l][i] != 0);
    return v;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (bus.lanes !== model_lanes()) begin
        errors++;
        $display("FAIL lanes @%0t: got %h want %h", $time, bus.lanes, model_lanes());
      end
      checks++;
      if (bus.score !== 8'(score_m)) begin
        errors++;
        $display("FAIL score @%0t: got %0d want %0d", $time, bus.score, score_m);
      end
      checks++;
      if (bus.combo !== 8'(combo_m)) begin
        errors++;
        $display("FAIL combo @%0t: got %0d want %0d", $time, bus.combo, combo_m);
      end
      checks++;
      if (bus.game_over !== over_m) begin
        errors++;
        $display("FAIL game_over @%0t: got %0d want %0d", $time, bus.game_over, over_m);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit t, input logic [3:0] sp, input logic [3:0] pr);
    bus.tick  = t;
    bus.spawn = sp;
    bus.press = pr;
    @(posedge clk);
    model_apply(t, sp, pr);
    #1;
    bus.tick  = 1'b0;
    bus.spawn = '0;
    bus.press = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset    = 1'b0;
    check_en = 1'b1;
  endtask

  // Assumes lane 0 is full and lanes 1..3 are empty; walks the score to target.
  task automatic bring_score(input int target);
    int guard = 0;
    while (score_m != target && guard < 2000) begin
      if (score_m + pts_now() <= target) step(1'b1, 4'b0001, 4'b0001);
      else step(1'b0, 4'b0000, 4'b1000);
      guard++;
    end
    checks++;
    if (score_m != target) begin
      errors++;
      $display("FAIL bring_score: got %0d want %0d", score_m, target);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.tick  = 1'b0;
    bus.spawn = '0;
    bus.press = '0;
    model_reset();
    do_reset();
    check_lit("reset_score", 32'(bus.score), 32'd0);
    check_lit("reset_lanes", bus.lanes, 32'd0);

    // Single note travels to the hit row and is hit.
    step(1'b1, 4'b0001, 4'b0000);
    for (int k = 0; k < 7; k++) step(1'b1, 4'b0000, 4'b0000);
    check_lit("t1_hitrow", 32'(bus.lanes[7]), 32'd1);
    step(1'b0, 4'b0000, 4'b0001);
    check_lit("t1_score", 32'(bus.score), 32'd3);
    check_lit("t1_combo", 32'(bus.combo), 32'd1);
    check_lit("t1_cleared", 32'(bus.lanes[7]), 32'd0);

    // Miss at score 0 floors.
    do_reset();
    step(1'b1, 4'b0010, 4'b0000);
    for (int k = 0; k < 7; k++) step(1'b1, 4'b0000, 4'b0000);
    check_lit("t2_hitrow", 32'(bus.lanes[15]), 32'd1);
    step(1'b1, 4'b0000, 4'b0000);
    check_lit("t2_score", 32'(bus.score), 32'd0);
    check_lit("t2_combo", 32'(bus.combo), 32'd0);
    check_lit("t2_lanes", bus.lanes, 32'd0);

    // Bad press from score 5.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0001, 4'b0000);
    bring_score(5);
    step(1'b0, 4'b0000, 4'b0100);
    check_lit("t3_score", 32'(bus.score), 32'd4);
    check_lit("t3_combo", 32'(bus.combo), 32'd0);

    // Clamp at MAX and freeze.
    bring_score(253);
    step(1'b1, 4'b0001, 4'b0001);
    check_lit("t4_score", 32'(bus.score), 32'd255);
    check_lit("t4_over", 32'(bus.game_over), 32'd1);
    step(1'b1, 4'b1111, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111);
    step(1'b1, 4'b1111, 4'b0000);
    check_lit("t4_frozen", 32'(bus.score), 32'd255);

    // Multi-lane hits and mixed hit/miss.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 4'b1111, 4'b0000);
    check_lit("t5_full", bus.lanes, 32'hFFFF_FFFF);
    step(1'b0, 4'b0000, 4'b0011);
    step(1'b0, 4'b0000, 4'b0011);
    step(1'b1, 4'b1111, 4'b1100);
    check_lit("t5_score10", 32'(bus.score), 32'd10);
    step(1'b1, 4'b1111, 4'b1111);
    check_lit("t5_score22", 32'(bus.score), 32'd22);
    check_lit("t5_combo6", 32'(bus.combo), 32'd6);
    step(1'b1, 4'b1111, 4'b0111);
    check_lit("t5_score30", 32'(bus.score), 32'd30);
    check_lit("t5_combo0", 32'(bus.combo), 32'd0);

    // Reset mid-operation.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0001, 4'b0000);
    for (int k = 0; k < 5; k++) step(1'b1, 4'b0001, 4'b0001);
    check_lit("t6_combo5", 32'(bus.combo), 32'd5);
    do_reset();
    check_lit("t6_lanes", bus.lanes, 32'd0);
    check_lit("t6_score", 32'(bus.score), 32'd0);
    check_lit("t6_combo", 32'(bus.combo), 32'd0);
    check_lit("t6_over", 32'(bus.game_over), 32'd0);

`ifdef COMBO_BONUS_EN
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0001, 4'b0000);
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0001, 4'b0001);
    check_lit("bonus_pre", 32'(bus.score), 32'd24);
    step(1'b1, 4'b0001, 4'b0001);
    check_lit("bonus_score", 32'(bus.score), 32'd28);
    check_lit("bonus_combo", 32'(bus.combo), 32'd9);
`endif

    @(negedge clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
